// File: rtl/btb_setassoc.sv
// Set-associative branch target buffer.
// Lookup is combinational on current_pc and returns hit, predicted direction
// and target. Resolved branches train the 2-bit counters, or allocate a new
// entry, through the update port. A flush invalidates one set per cycle.
module btb_setassoc #(
  parameter int SETS  = 16,
  parameter int WAYS  = 2,
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] current_pc,
  output logic        btb_hit,
  output logic        btb_taken,
  output logic [31:0] btb_target_pc,
  input  logic        update,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] real_target_pc,
  input  logic        flush,
  output logic        flush_busy
);

  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MIN  = '0;
  localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(SETS - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Entry state: valid bits and counters are reset; tags and targets are
  // plain storage because every read of them is qualified by valid.
  logic             valid_q  [SETS][WAYS];
  logic [CNT_W-1:0] cnt_q    [SETS][WAYS];
  logic [TAG_W-1:0] tag_q    [SETS][WAYS];
  logic [31:0]      target_q [SETS][WAYS];

  state_e           state_q;
  logic [IDX_W-1:0] flush_cnt_q;
  logic             flush_busy_q;

  // Lookup side
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_match;
  logic [WAY_W-1:0] lk_way;

  // Update side
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_en;
  logic             upd_hit;
  logic [WAY_W-1:0] upd_way;
  logic             upd_free;
  logic [WAY_W-1:0] free_way;
  logic [WAY_W-1:0] rr_cur;
  logic [WAY_W-1:0] victim;
  logic             alloc_en;
  logic             rr_adv;

  assign lk_idx  = current_pc[IDX_W+1:2];
  assign lk_tag  = current_pc[31:IDX_W+2];
  assign upd_idx = update_pc[IDX_W+1:2];
  assign upd_tag = update_pc[31:IDX_W+2];

  // Tag compare for the fetch PC; descending scan so the lowest way wins
  always_comb begin
    lk_match = 1'b0;
    lk_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
        lk_match = 1'b1;
        lk_way   = WAY_W'(w);
      end
    end
  end

  // Prediction outputs, suppressed while a flush is sweeping the array
  always_comb begin
    btb_hit       = lk_match && (state_q == ST_IDLE);
    btb_taken     = btb_hit && cnt_q[lk_idx][lk_way][CNT_W-1];
    btb_target_pc = btb_hit ? target_q[lk_idx][lk_way] : 32'h0;
  end

  // Tag compare and free-way search for the resolving branch
  always_comb begin
    upd_hit  = 1'b0;
    upd_way  = '0;
    upd_free = 1'b0;
    free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[upd_idx][w] && (tag_q[upd_idx][w] == upd_tag)) begin
        upd_hit = 1'b1;
        upd_way = WAY_W'(w);
      end
      if (!valid_q[upd_idx][w]) begin
        upd_free = 1'b1;
        free_way = WAY_W'(w);
      end
    end
  end

  // Updates are accepted only when idle and not colliding with a flush request
  assign upd_en   = update && (state_q == ST_IDLE) && !flush;
  assign alloc_en = upd_en && !upd_hit && update_taken;
  assign rr_adv   = alloc_en && !upd_free;
  assign victim   = upd_free ? free_way : rr_cur;

  generate
    if (WAYS > 1) begin : g_rr
      logic [WAY_W-1:0] rr_q [SETS];

      assign rr_cur = rr_q[upd_idx];

      // Round-robin pointer moves only when a valid entry was evicted
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int s = 0; s < SETS; s++) begin
            rr_q[s] <= '0;
          end
        end else if (rr_adv) begin
          rr_q[upd_idx] <= rr_q[upd_idx] + WAY_W'(1);
        end
      end
    end else begin : g_no_rr
      // Direct-mapped: the only way is always the victim
      assign rr_cur = '0;
    end
  endgenerate

  // Flush FSM, valid bits and direction counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      flush_cnt_q  <= '0;
      flush_busy_q <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          cnt_q[s][w]   <= CNT_INIT;
        end
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (flush) begin
            state_q      <= ST_FLUSH;
            flush_cnt_q  <= '0;
            flush_busy_q <= 1'b1;
          end else if (upd_en) begin
            if (upd_hit) begin
              if (update_taken) begin
                if (cnt_q[upd_idx][upd_way] != CNT_MAX) begin
                  cnt_q[upd_idx][upd_way] <= cnt_q[upd_idx][upd_way] + CNT_W'(1);
                end
              end else if (cnt_q[upd_idx][upd_way] != CNT_MIN) begin
                cnt_q[upd_idx][upd_way] <= cnt_q[upd_idx][upd_way] - CNT_W'(1);
              end
            end else if (update_taken) begin
              valid_q[upd_idx][victim] <= 1'b1;
              cnt_q[upd_idx][victim]   <= CNT_INIT;
            end
          end
        end
        ST_FLUSH: begin
          for (int w = 0; w < WAYS; w++) begin
            valid_q[flush_cnt_q][w] <= 1'b0;
          end
          flush_cnt_q <= flush_cnt_q + IDX_W'(1);
          if (flush_cnt_q == LAST_SET) begin
            state_q      <= ST_IDLE;
            flush_busy_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          flush_busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Tag and target storage: written on hit-taken (target) or allocation
  always_ff @(posedge clk) begin
    if (upd_en) begin
      if (upd_hit) begin
        if (update_taken) begin
          target_q[upd_idx][upd_way] <= real_target_pc;
        end
      end else if (update_taken) begin
        tag_q[upd_idx][victim]    <= upd_tag;
        target_q[upd_idx][victim] <= real_target_pc;
      end
    end
  end

  assign flush_busy = flush_busy_q;

endmodule

// File: tb/tb_btb_setassoc.sv
// Directed bench for btb_setassoc (SETS=16, WAYS=2, CNT_W=2).
module tb_btb_setassoc;

  logic        clk;
  logic        reset;
  logic [31:0] current_pc;
  logic        btb_hit;
  logic        btb_taken;
  logic [31:0] btb_target_pc;
  logic        update;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] real_target_pc;
  logic        flush;
  logic        flush_busy;

  int checks_cnt;
  int fail_cnt;
  int busy_cycles;

  btb_setassoc #(.SETS(16), .WAYS(2), .CNT_W(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .current_pc    (current_pc),
    .btb_hit       (btb_hit),
    .btb_taken     (btb_taken),
    .btb_target_pc (btb_target_pc),
    .update        (update),
    .update_pc     (update_pc),
    .update_taken  (update_taken),
    .real_target_pc(real_target_pc),
    .flush         (flush),
    .flush_busy    (flush_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  // One update pulse captured on the next rising edge
  task automatic do_update(input logic [31:0] pc, input logic tkn, input logic [31:0] tgt);
    update         = 1'b1;
    update_pc      = pc;
    update_taken   = tkn;
    real_target_pc = tgt;
    @(posedge clk);
    #1;
    update = 1'b0;
  endtask

  // Combinational lookup check of hit/taken/target
  task automatic look(input string tag, input logic [31:0] pc, input logic eh,
                      input logic et, input logic [31:0] etgt);
    current_pc = pc;
    #1;
    check_val({tag, ".hit"},    {31'b0, btb_hit},   {31'b0, eh});
    check_val({tag, ".taken"},  {31'b0, btb_taken}, {31'b0, et});
    check_val({tag, ".target"}, btb_target_pc,      etgt);
  endtask

  initial begin
    checks_cnt     = 0;
    fail_cnt       = 0;
    reset          = 1'b0;
    current_pc     = 32'h0000_1000;
    update         = 1'b0;
    update_pc      = 32'h0;
    update_taken   = 1'b0;
    real_target_pc = 32'h0;
    flush          = 1'b0;

    // Outputs while reset is held
    repeat (2) @(posedge clk);
    #1;
    check_val("rst.busy", {31'b0, flush_busy}, 32'h0);
    look("rst", 32'h0000_1000, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    look("t1", 32'h0000_1000, 1'b0, 1'b0, 32'h0);

    // Allocate and hit; same set, other tag misses
    do_update(32'h0000_1000, 1'b1, 32'h0000_2000);
    look("t2.hit",  32'h0000_1000, 1'b1, 1'b1, 32'h0000_2000);
    look("t2.alt",  32'h0000_1040, 1'b0, 1'b0, 32'h0);

    // Counter saturation; not-taken leaves target alone
    do_update(32'h0000_1000, 1'b0, 32'hDEAD_0000);
    look("t3.nt1", 32'h0000_1000, 1'b1, 1'b0, 32'h0000_2000);
    do_update(32'h0000_1000, 1'b0, 32'hDEAD_0000);
    look("t3.nt2", 32'h0000_1000, 1'b1, 1'b0, 32'h0000_2000);
    do_update(32'h0000_1000, 1'b0, 32'hDEAD_0000);
    do_update(32'h0000_1000, 1'b1, 32'h0000_3000);
    look("t3.t1",  32'h0000_1000, 1'b1, 1'b0, 32'h0000_3000);
    do_update(32'h0000_1000, 1'b1, 32'h0000_3000);
    look("t3.t2",  32'h0000_1000, 1'b1, 1'b1, 32'h0000_3000);
    do_update(32'h0000_1000, 1'b1, 32'h0000_3000);
    do_update(32'h0000_1000, 1'b1, 32'h0000_3000);
    do_update(32'h0000_1000, 1'b0, 32'hDEAD_0000);
    look("t3.sat3", 32'h0000_1000, 1'b1, 1'b1, 32'h0000_3000);
    do_update(32'h0000_1000, 1'b0, 32'hDEAD_0000);
    look("t3.dec1", 32'h0000_1000, 1'b1, 1'b0, 32'h0000_3000);

    // Replacement: free way first, then round robin
    do_update(32'h0000_1040, 1'b1, 32'h0000_A040);
    do_update(32'h0000_1080, 1'b1, 32'h0000_A080);
    look("t4.a",  32'h0000_1000, 1'b0, 1'b0, 32'h0);
    look("t4.b",  32'h0000_1040, 1'b1, 1'b1, 32'h0000_A040);
    look("t4.c",  32'h0000_1082, 1'b1, 1'b1, 32'h0000_A080);
    do_update(32'h0000_10C0, 1'b1, 32'h0000_A0C0);
    look("t4.d",  32'h0000_1040, 1'b0, 1'b0, 32'h0);
    look("t4.e",  32'h0000_1080, 1'b1, 1'b1, 32'h0000_A080);
    look("t4.f",  32'h0000_10C0, 1'b1, 1'b1, 32'h0000_A0C0);

    // Flush: drive set-1 entry counter to 0 first
    do_update(32'h0000_2004, 1'b1, 32'h0000_B004);
    do_update(32'h0000_2004, 1'b0, 32'h0);
    do_update(32'h0000_2004, 1'b0, 32'h0);
    look("t5.pre", 32'h0000_2004, 1'b1, 1'b0, 32'h0000_B004);
    flush          = 1'b1;
    update         = 1'b1;
    update_pc      = 32'h0000_400C;
    update_taken   = 1'b1;
    real_target_pc = 32'h0000_C00C;
    @(posedge clk);
    #1;
    flush       = 1'b0;
    update      = 1'b0;
    busy_cycles = 0;
    current_pc  = 32'h0000_10C0;
    for (int i = 0; i < 40; i++) begin
      if (flush_busy) busy_cycles++;
      if (i == 2) begin
        check_val("t5.dur.hit", {31'b0, btb_hit}, 32'h0);
        check_val("t5.dur.tgt", btb_target_pc, 32'h0);
        update         = 1'b1;
        update_pc      = 32'h0000_3008;
        update_taken   = 1'b1;
        real_target_pc = 32'h0000_D008;
        flush          = 1'b1;
      end
      if (i == 3) begin
        update = 1'b0;
        flush  = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    check_val("t5.busy_cycles", busy_cycles, 32'd16);
    look("t5.post1", 32'h0000_10C0, 1'b0, 1'b0, 32'h0);
    look("t5.post2", 32'h0000_2004, 1'b0, 1'b0, 32'h0);
    look("t5.drop",  32'h0000_3008, 1'b0, 1'b0, 32'h0);
    look("t5.fwin",  32'h0000_400C, 1'b0, 1'b0, 32'h0);
    do_update(32'h0000_2004, 1'b1, 32'h0000_E004);
    look("t5.realloc", 32'h0000_2004, 1'b1, 1'b1, 32'h0000_E004);
    do_update(32'h0000_2004, 1'b0, 32'h0);
    look("t5.init", 32'h0000_2004, 1'b1, 1'b0, 32'h0000_E004);

    // Reset in the middle of a flush
    do_update(32'h0000_103C, 1'b1, 32'h0000_F03C);
    look("t6.pre", 32'h0000_103C, 1'b1, 1'b1, 32'h0000_F03C);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check_val("t6.busy_pre", {31'b0, flush_busy}, 32'h1);
    reset = 1'b0;
    #1;
    check_val("t6.busy_rst", {31'b0, flush_busy}, 32'h0);
    look("t6.rst", 32'h0000_103C, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_val("t6.busy_rel", {31'b0, flush_busy}, 32'h0);
    do_update(32'h0000_103C, 1'b1, 32'h0000_703C);
    look("t6.post", 32'h0000_103C, 1'b1, 1'b1, 32'h0000_703C);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
